// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator and 1-bpp framebuffer scanout.
// A 320x240 image is pixel-doubled in both axes. The raster counters (stage 0)
// feed a 3-register pipeline: address (stage 1), buffer read (stage 2) and
// colour/sync output (stage 3). All pins are registered and mutually aligned.
// The buffer port is a free-running read with fixed 1-clock latency; there is
// no handshake and the block never stalls.
module vga_scanout #(
  parameter int          DATA_WIDTH           = 16,
  parameter int          BUFFER_ADDRESS_WIDTH = 13,
  parameter int          H_ACTIVE             = 640,
  parameter int          H_FP                 = 16,
  parameter int          H_SYNC               = 96,
  parameter int          H_BP                 = 48,
  parameter int          V_ACTIVE             = 480,
  parameter int          V_FP                 = 10,
  parameter int          V_SYNC               = 2,
  parameter int          V_BP                 = 33,
  parameter int          WORDS_PER_LINE       = 20,
  parameter logic [11:0] FG_COLOR             = 12'hFFF,
  parameter logic [11:0] BG_COLOR             = 12'h000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] bufferAddress,
  input  logic [DATA_WIDTH-1:0]           bufferData,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            de,
  output logic [11:0]                     rgb,
  output logic                            vblank,
  output logic                            frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int IW      = $clog2(DATA_WIDTH);
  localparam int AW      = BUFFER_ADDRESS_WIDTH;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DATA_WIDTH - 1);
  localparam logic [AW-1:0] WPL       = AW'(WORDS_PER_LINE);

  // Per-pixel control that rides the pipeline next to the data path.
  // Sync levels are carried at pin polarity (active-low) so reset = idle pins.
  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
    logic vb;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, vb: 1'b0, fs: 1'b0};

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  ctl_t          ctl0, ctl1_q, ctl2_q, ctl3_q;
  logic [IW-1:0] idx0, idx1_q, idx2_q;
  logic [AW-1:0] row0, col0, addr0, addr_q;
  logic [11:0]   rgb_q;

  // Raster counter next state: hCount wraps at line end and steps vCount.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Stage-0 raster counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage-0 decode: region, sync levels, buffer word address and bit index.
  // Each word covers 2*DATA_WIDTH screen pixels; each row covers 2 lines.
  // The constant multiply by WORDS_PER_LINE (20) reduces to (r<<4)+(r<<2).
  always_comb begin
    ctl0      = CTL_IDLE;
    ctl0.act  = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    ctl0.hs_n = !((h_q >= HS_START) && (h_q < HS_END));
    ctl0.vs_n = !((v_q >= VS_START) && (v_q < VS_END));
    ctl0.vb   = (v_q >= V_ACT_END);
    ctl0.fs   = (h_q == '0) && (v_q == '0);
    idx0      = IDX_MAX - h_q[IW:1];
    row0      = AW'(v_q >> 1);
    col0      = AW'(h_q >> (IW + 1));
    addr0     = ctl0.act ? (row0 * WPL + col0) : '0;
  end

  // Stage 1: register the buffer address; bit index and control follow it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      idx1_q <= '0;
      ctl1_q <= CTL_IDLE;
    end else begin
      addr_q <= addr0;
      idx1_q <= idx0;
      ctl1_q <= ctl0;
    end
  end

  // Stage 2: the buffer samples addr_q; index and control wait for its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx2_q <= '0;
      ctl2_q <= CTL_IDLE;
    end else begin
      idx2_q <= idx1_q;
      ctl2_q <= ctl1_q;
    end
  end

  // Stage 3: select the pixel bit from the returned word and register pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      ctl3_q <= CTL_IDLE;
    end else begin
      rgb_q  <= !ctl2_q.act ? 12'h000 : (bufferData[idx2_q] ? FG_COLOR : BG_COLOR);
      ctl3_q <= ctl2_q;
    end
  end

  assign bufferAddress = addr_q;
  assign rgb           = rgb_q;
  assign de            = ctl3_q.act;
  assign hsync         = ctl3_q.hs_n;
  assign vsync         = ctl3_q.vs_n;
  assign vblank        = ctl3_q.vb;
  assign frameStart    = ctl3_q.fs;

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout. Horizontal timing is the real 800-clock line;
// vertical timing is shortened (20 active lines, 28 total) so whole frames fit
// in a short run. Expected pins come from a raster-position model: outputs at
// cycle c reflect raster position c-3, the address reflects position c-1.
`timescale 1ns/1ps
module tb_vga_scanout;
  localparam int DW     = 16;
  localparam int AW     = 13;
  localparam int HA     = 640;
  localparam int HF     = 16;
  localparam int HS     = 96;
  localparam int HB     = 48;
  localparam int VA     = 20;
  localparam int VF     = 2;
  localparam int VS     = 2;
  localparam int VB     = 4;
  localparam int WPL    = 20;
  localparam int HT     = HA + HF + HS + HB;
  localparam int VT     = VA + VF + VS + VB;
  localparam int FRAME  = HT * VT;
  localparam int NWORDS = (VA / 2) * WPL;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] bufferAddress;
  logic [DW-1:0] bufferData;
  logic          hsync, vsync, de, vblank, frameStart;
  logic [11:0]   rgb;

  logic [DW-1:0] mem [NWORDS];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick = 0;
  bit started = 1'b0;
  bit rst_edge;

  vga_scanout #(
    .DATA_WIDTH(DW), .BUFFER_ADDRESS_WIDTH(AW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .WORDS_PER_LINE(WPL), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bufferAddress(bufferAddress), .bufferData(bufferData),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .vblank(vblank), .frameStart(frameStart)
  );

  // clock/reset block: 25 MHz pixel clock
  always #20 clk = ~clk;

  // display buffer: synchronous read, data valid the cycle after the address
  always @(posedge clk)
    bufferData <= (int'(bufferAddress) < NWORDS) ? mem[bufferAddress] : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  // behavioural model: pin values for c clocks after the last reset edge
  function automatic void model_pins(input int c, output logic [11:0] rgb_e,
                                     output logic de_e, output logic hs_e, output logic vs_e,
                                     output logic vb_e, output logic fs_e,
                                     output logic [AW-1:0] addr_e);
    int p, h, v;
    logic [DW-1:0] w;
    rgb_e = 12'h000; de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; vb_e = 1'b0; fs_e = 1'b0;
    addr_e = '0;
    if (c >= 1) begin
      p = (c - 1) % FRAME; h = p % HT; v = p / HT;
      if (h < HA && v < VA) addr_e = AW'((v / 2) * WPL + h / (2 * DW));
    end
    if (c >= 3) begin
      p = (c - 3) % FRAME; h = p % HT; v = p / HT;
      de_e = (h < HA) && (v < VA);
      hs_e = !(h >= HA + HF && h < HA + HF + HS);
      vs_e = !(v >= VA + VF && v < VA + VF + VS);
      vb_e = (v >= VA);
      fs_e = (p == 0);
      if (de_e) begin
        w = mem[(v / 2) * WPL + h / (2 * DW)];
        rgb_e = w[DW - 1 - (h / 2) % DW] ? FG : BG;
      end
    end
  endfunction

  // scoreboard state for pin-level interval measurements
  logic [11:0]   e_rgb;
  logic          e_de, e_hs, e_vs, e_vb, e_fs;
  logic [AW-1:0] e_addr;
  int de_run, hs_run, vs_run, vb_run, de_rise_tick, hs_fall_tick, fs_tick;
  bit de_ok, hs_ok, vs_ok, vb_ok, rise_ok, hsp_ok, fs_ok;
  logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1, p_vb = 1'b0;

  // compare process: every cycle after the first reset edge
  always @(posedge clk) begin
    rst_edge = !rst_n;
    tick++;
    if (rst_edge) begin
      cyc = 0;
      started = 1'b1;
    end else if (started) begin
      cyc++;
    end
    #1;
    if (started) begin
      model_pins(cyc, e_rgb, e_de, e_hs, e_vs, e_vb, e_fs, e_addr);
      check("rgb",           32'(rgb),           32'(e_rgb));
      check("de",            32'(de),            32'(e_de));
      check("hsync",         32'(hsync),         32'(e_hs));
      check("vsync",         32'(vsync),         32'(e_vs));
      check("vblank",        32'(vblank),        32'(e_vb));
      check("frameStart",    32'(frameStart),    32'(e_fs));
      check("bufferAddress", 32'(bufferAddress), 32'(e_addr));

      if (rst_edge) begin
        de_ok = 0; hs_ok = 0; vs_ok = 0; vb_ok = 0; rise_ok = 0; hsp_ok = 0; fs_ok = 0;
      end
      if (de === 1'b1 && p_de !== 1'b1) begin
        de_run = 1; de_ok = 1; rise_ok = 1; de_rise_tick = tick;
      end else if (de === 1'b1) begin
        de_run++;
      end else if (p_de === 1'b1 && de_ok) begin
        check("de_high_clocks", 32'(de_run), 32'd640);
      end
      if (hsync === 1'b0 && p_hs !== 1'b0) begin
        hs_run = 1; hs_ok = 1;
        if (rise_ok) check("hsync_fall_after_de", 32'(tick - de_rise_tick), 32'd656);
        rise_ok = 0;
        if (hsp_ok) check("line_period", 32'(tick - hs_fall_tick), 32'd800);
        hs_fall_tick = tick; hsp_ok = 1;
      end else if (hsync === 1'b0) begin
        hs_run++;
      end else if (p_hs === 1'b0 && hs_ok) begin
        check("hsync_low_clocks", 32'(hs_run), 32'd96);
      end
      if (vsync === 1'b0 && p_vs !== 1'b0) begin
        vs_run = 1; vs_ok = 1;
      end else if (vsync === 1'b0) begin
        vs_run++;
      end else if (p_vs === 1'b0 && vs_ok) begin
        check("vsync_low_clocks", 32'(vs_run), 32'd1600);
      end
      if (vblank === 1'b1 && p_vb !== 1'b1) begin
        vb_run = 1; vb_ok = 1;
      end else if (vblank === 1'b1) begin
        vb_run++;
      end else if (p_vb === 1'b1 && vb_ok) begin
        check("vblank_high_clocks", 32'(vb_run), 32'd6400);
      end
      if (frameStart === 1'b1) begin
        if (fs_ok) check("frame_period", 32'(tick - fs_tick), 32'd22400);
        fs_tick = tick; fs_ok = 1;
      end
      p_de = de; p_hs = hsync; p_vs = vsync; p_vb = vblank;
    end
  end

  // driver: wait until the model cycle count reaches target (bounded)
  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 2 * FRAME) begin
      @(posedge clk); #2;
      n++;
    end
    if (cyc != target) check("wait_timeout", 32'(cyc), 32'(target));
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_addr"},   32'(bufferAddress), 32'd0);
    check({tag, "_hsync"},  32'(hsync),         32'd1);
    check({tag, "_vsync"},  32'(vsync),         32'd1);
    check({tag, "_de"},     32'(de),            32'd0);
    check({tag, "_rgb"},    32'(rgb),           32'd0);
    check({tag, "_vblank"}, 32'(vblank),        32'd0);
    check({tag, "_fs"},     32'(frameStart),    32'd0);
  endtask

  initial begin
    int n;
    int px;
    for (int i = 0; i < NWORDS; i++) mem[i] = DW'($urandom);

    // reset held 5 clocks
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_reset_pins("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #2;
      check("fs_after_release", 32'(frameStart), 32'(k == 3));
      check("de_after_release", 32'(de),         32'(k == 3));
    end

    // address sequence on display line 2, then end of the last active line
    wait_cyc(2 * HT + 1);
    for (int i = 0; i <= HA; i++) begin
      case (i)
        0:       check("addr_line2_px0",   32'(bufferAddress), 32'd20);
        31:      check("addr_line2_px31",  32'(bufferAddress), 32'd20);
        32:      check("addr_line2_px32",  32'(bufferAddress), 32'd21);
        639:     check("addr_line2_px639", 32'(bufferAddress), 32'd39);
        640:     check("addr_line2_blank", 32'(bufferAddress), 32'd0);
        default: ;
      endcase
      @(posedge clk); #2;
    end
    wait_cyc((VA - 1) * HT + HA);
    check("addr_last_active", 32'(bufferAddress), 32'd199);
    @(posedge clk); #2;
    check("addr_after_last", 32'(bufferAddress), 32'd0);
    wait_cyc(FRAME + 1000);

    // one-clock reset at raster (line 12, pixel 300) in the second frame
    wait_cyc(FRAME + 12 * HT + 300);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NWORDS; i++) mem[i] = DW'($urandom);
    @(posedge clk); #2;
    check_reset_pins("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(FRAME + 1000);

    // random-length reset at a random point; load the pixel pattern under it
    n = $urandom_range(500, 8000);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NWORDS; i++) mem[i] = '0;
    mem[0] = 16'h8001;
    repeat ($urandom_range(1, 4)) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < 2 * HT; i++) begin
      px = i % HT;
      case (px)
        0, 1, 30, 31:    check("pattern_fg", 32'(rgb), 32'h0000_0FFF);
        2, 29, 32, 639:  check("pattern_bg", 32'(rgb), 32'h0000_0000);
        default: ;
      endcase
      @(posedge clk); #2;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #6000000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
